// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the 5-stage MIPS pipeline: word/register types,
// ALU operation encoding, forwarding selects and the EX/MEM latch layout.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Encoding 3 is unused by the forwarding unit and falls back to ID/EX.
    typedef enum logic [1:0] {
        FWD_ID  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        word_t    aluout;
        word_t    wdat;
        word_t    npc;
        regbits_t wreg;
        logic     reg_wen;
        logic     dwen;
        logic     dren;
        logic     mem_to_reg;
        logic     jaltype;
        logic     halt;
    } exmem_t;

endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU: arithmetic/logic ops modulo 2^32, no overflow traps.
// Shifts act on b by shamt; zero flags an all-zero result.
module alu
    import cpu_types_pkg::*;
(
    input  word_t      a,
    input  word_t      b,
    input  logic [4:0] shamt,
    input  aluop_t     aluop,
    output word_t      result,
    output logic       zero
);

    logic lt_signed;
    logic lt_unsigned;

    always_comb begin
        lt_signed   = $signed(a) < $signed(b);
        lt_unsigned = a < b;
        result      = '0;
        case (aluop)
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WORD_BITS-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(WORD_BITS-1){1'b0}}, lt_unsigned};
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU evaluation, branch/jr resolution and the
// EX/MEM pipeline latch (load / bubble / hold, frozen once a halt reaches it).
module execute_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dstall,
    input  logic              flush,
    input  logic [WORD_W-1:0] rdat1_r,
    input  logic [WORD_W-1:0] rdat2_r,
    input  logic [WORD_W-1:0] extOut_r,
    input  logic [WORD_W-1:0] npc_r,
    input  logic [REG_W-1:0]  wreg_r,
    input  logic [REG_W-1:0]  rs_r,
    input  logic [REG_W-1:0]  rt_r,
    input  aluop_t            ALUOP_r,
    input  logic              alutype_r,
    input  logic              Reg_Wen_r,
    input  logic              dwen_r,
    input  logic              dren_r,
    input  logic              MemToReg_r,
    input  logic              jaltype_r,
    input  logic              jrtype_r,
    input  logic              branch_r,
    input  logic              bne_r,
    input  logic              halt_r,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [WORD_W-1:0] mem_fwd,
    input  logic [WORD_W-1:0] wb_fwd,
    output logic              pc_redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] aluout_m,
    output logic [WORD_W-1:0] wdat_m,
    output logic [WORD_W-1:0] npc_m,
    output logic [REG_W-1:0]  wreg_m,
    output logic              Reg_Wen_m,
    output logic              dwen_m,
    output logic              dren_m,
    output logic              MemToReg_m,
    output logic              jaltype_m,
    output logic              halt_m
);

    word_t  opnd_a;
    word_t  fwd_b_val;
    word_t  alu_b;
    word_t  alu_result;
    logic   alu_zero_unused;
    logic   br_eq;
    logic   latch_en;
    exmem_t exm_d;
    exmem_t exm_q;

    // rs/rt are consumed by the forwarding unit upstream, not here.
    logic   idx_unused;
    assign idx_unused = ^{rs_r, rt_r};

    always_comb begin
        case (fwd_sel_t'(fwd_a))
            FWD_MEM: opnd_a = mem_fwd;
            FWD_WB:  opnd_a = wb_fwd;
            default: opnd_a = rdat1_r;
        endcase
        case (fwd_sel_t'(fwd_b))
            FWD_MEM: fwd_b_val = mem_fwd;
            FWD_WB:  fwd_b_val = wb_fwd;
            default: fwd_b_val = rdat2_r;
        endcase
        alu_b = alutype_r ? extOut_r : fwd_b_val;
    end

    alu u_alu (
        .a      (opnd_a),
        .b      (alu_b),
        .shamt  (extOut_r[10:6]),
        .aluop  (ALUOP_r),
        .result (alu_result),
        .zero   (alu_zero_unused)
    );

    // A halted pipeline must not steer fetch anywhere.
    always_comb begin
        br_eq       = (opnd_a == fwd_b_val);
        pc_redirect = ((branch_r & (br_eq ^ bne_r)) | jrtype_r) & ~exm_q.halt;
        redirect_pc = jrtype_r ? opnd_a : npc_r + (extOut_r << 2);
    end

    // A completed data access (dhit) releases the stall in the same cycle.
    always_comb begin
        latch_en = ihit & (~dstall | dhit);
        exm_d    = exm_q;
        if (!exm_q.halt && latch_en) begin
            if (flush) begin
                exm_d = '0;
            end else begin
                exm_d.aluout     = alu_result;
                exm_d.wdat       = fwd_b_val;
                exm_d.npc        = npc_r;
                exm_d.wreg       = wreg_r;
                exm_d.reg_wen    = Reg_Wen_r;
                exm_d.dwen       = dwen_r;
                exm_d.dren       = dren_r;
                exm_d.mem_to_reg = MemToReg_r;
                exm_d.jaltype    = jaltype_r;
                exm_d.halt       = halt_r;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exm_q <= '0;
        end else begin
            exm_q <= exm_d;
        end
    end

    assign aluout_m   = exm_q.aluout;
    assign wdat_m     = exm_q.wdat;
    assign npc_m      = exm_q.npc;
    assign wreg_m     = exm_q.wreg;
    assign Reg_Wen_m  = exm_q.reg_wen;
    assign dwen_m     = exm_q.dwen;
    assign dren_m     = exm_q.dren;
    assign MemToReg_m = exm_q.mem_to_reg;
    assign jaltype_m  = exm_q.jaltype;
    assign halt_m     = exm_q.halt;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU corners, branch resolution,
// and the EX/MEM load/hold/bubble/halt behaviour.
module tb_execute_stage;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, dstall, flush;
    logic [31:0] rdat1_r, rdat2_r, extOut_r, npc_r;
    logic [4:0]  wreg_r, rs_r, rt_r;
    aluop_t      ALUOP_r;
    logic        alutype_r, Reg_Wen_r, dwen_r, dren_r, MemToReg_r;
    logic        jaltype_r, jrtype_r, branch_r, bne_r, halt_r;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] mem_fwd, wb_fwd;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] aluout_m, wdat_m, npc_m;
    logic [4:0]  wreg_m;
    logic        Reg_Wen_m, dwen_m, dren_m, MemToReg_m, jaltype_m, halt_m;

    int n_cmp;
    int n_fail;

    execute_stage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dstall(dstall), .flush(flush),
        .rdat1_r(rdat1_r), .rdat2_r(rdat2_r), .extOut_r(extOut_r), .npc_r(npc_r),
        .wreg_r(wreg_r), .rs_r(rs_r), .rt_r(rt_r), .ALUOP_r(ALUOP_r),
        .alutype_r(alutype_r), .Reg_Wen_r(Reg_Wen_r), .dwen_r(dwen_r), .dren_r(dren_r),
        .MemToReg_r(MemToReg_r), .jaltype_r(jaltype_r), .jrtype_r(jrtype_r),
        .branch_r(branch_r), .bne_r(bne_r), .halt_r(halt_r),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .aluout_m(aluout_m), .wdat_m(wdat_m), .npc_m(npc_m), .wreg_m(wreg_m),
        .Reg_Wen_m(Reg_Wen_m), .dwen_m(dwen_m), .dren_m(dren_m),
        .MemToReg_m(MemToReg_m), .jaltype_m(jaltype_m), .halt_m(halt_m)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 1'b0; dhit = 1'b0; dstall = 1'b0; flush = 1'b0;
        rdat1_r = '0; rdat2_r = '0; extOut_r = '0; npc_r = '0;
        wreg_r = '0; rs_r = '0; rt_r = '0; ALUOP_r = ALU_ADD;
        alutype_r = 1'b0; Reg_Wen_r = 1'b0; dwen_r = 1'b0; dren_r = 1'b0;
        MemToReg_r = 1'b0; jaltype_r = 1'b0; jrtype_r = 1'b0; branch_r = 1'b0;
        bne_r = 1'b0; halt_r = 1'b0; fwd_a = 2'd0; fwd_b = 2'd0;
        mem_fwd = '0; wb_fwd = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        ihit = 1'b1; rdat1_r = 32'h11; rdat2_r = 32'h22; npc_r = 32'h44;
        wreg_r = 5'd9; Reg_Wen_r = 1'b1; dwen_r = 1'b1; dren_r = 1'b1;
        MemToReg_r = 1'b1; jaltype_r = 1'b1; halt_r = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({aluout_m, wdat_m, npc_m} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h, want 0 0 0", aluout_m, wdat_m, npc_m);
        end
        n_cmp++;
        if ({wreg_m, Reg_Wen_m, dwen_m, dren_m, MemToReg_m, jaltype_m, halt_m} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got wreg=%0d ctl=%b%b%b%b%b%b, want 0", wreg_m,
                     Reg_Wen_m, dwen_m, dren_m, MemToReg_m, jaltype_m, halt_m);
        end
        clear_inputs();
        #2 nRST = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        ihit = 1'b1; ALUOP_r = ALU_ADD; rdat1_r = 32'd5; rdat2_r = 32'd7;
        npc_r = 32'h24; wreg_r = 5'd3; Reg_Wen_r = 1'b1;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd12 || wdat_m !== 32'd7 || npc_m !== 32'h24) begin
            n_fail++;
            $display("FAIL add_id: got alu=%0d wdat=%0d npc=%h, want 12 7 24", aluout_m, wdat_m, npc_m);
        end
        n_cmp++;
        if (wreg_m !== 5'd3 || Reg_Wen_m !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ctrl: got wreg=%0d wen=%b, want 3 1", wreg_m, Reg_Wen_m);
        end
        fwd_a = 2'd1; mem_fwd = 32'd100;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd107) begin
            n_fail++;
            $display("FAIL fwd_mem_a: got %0d, want 107", aluout_m);
        end
        fwd_a = 2'd3; rdat1_r = 32'd20;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd27) begin
            n_fail++;
            $display("FAIL fwd_sel3_a: got %0d, want 27", aluout_m);
        end
    endtask

    task automatic test_store_imm();
        fwd_a = 2'd0; rdat1_r = 32'd5; alutype_r = 1'b1; extOut_r = 32'd4;
        fwd_b = 2'd2; wb_fwd = 32'hDEAD; dwen_r = 1'b1; Reg_Wen_r = 1'b0;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd9 || wdat_m !== 32'hDEAD || dwen_m !== 1'b1) begin
            n_fail++;
            $display("FAIL store_imm: got alu=%0d wdat=%h dwen=%b, want 9 dead 1", aluout_m, wdat_m, dwen_m);
        end
        alutype_r = 1'b0; fwd_b = 2'd1; mem_fwd = 32'd30;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd35 || wdat_m !== 32'd30) begin
            n_fail++;
            $display("FAIL fwd_mem_b: got alu=%0d wdat=%0d, want 35 30", aluout_m, wdat_m);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        branch_r = 1'b1; bne_r = 1'b0; rdat1_r = 32'd3; rdat2_r = 32'd3;
        npc_r = 32'h40; extOut_r = 32'd2;
        #1;
        n_cmp++;
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h48) begin
            n_fail++;
            $display("FAIL beq_taken: got redir=%b pc=%h, want 1 48", pc_redirect, redirect_pc);
        end
        bne_r = 1'b1;
        #1;
        n_cmp++;
        if (pc_redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_equal: got redir=%b, want 0", pc_redirect);
        end
        rdat2_r = 32'd4;
        #1;
        n_cmp++;
        if (pc_redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_taken: got redir=%b, want 1", pc_redirect);
        end
        branch_r = 1'b0; bne_r = 1'b0; jrtype_r = 1'b1; rdat1_r = 32'h100;
        #1;
        n_cmp++;
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL jr: got redir=%b pc=%h, want 1 100", pc_redirect, redirect_pc);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall_hold();
        ihit = 1'b1; rdat1_r = 32'd1; rdat2_r = 32'd2; npc_r = 32'h10; Reg_Wen_r = 1'b1;
        tick();
        dstall = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdat1_r = 32'd50 + i; npc_r = 32'h80 + i; Reg_Wen_r = 1'b0;
            tick();
            n_cmp++;
            if (aluout_m !== 32'd3 || npc_m !== 32'h10 || Reg_Wen_m !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got alu=%0d npc=%h wen=%b, want 3 10 1",
                         i, aluout_m, npc_m, Reg_Wen_m);
            end
        end
        dhit = 1'b1; rdat1_r = 32'd20; rdat2_r = 32'd22; npc_r = 32'h90;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd42 || npc_m !== 32'h90) begin
            n_fail++;
            $display("FAIL stall_release: got alu=%0d npc=%h, want 42 90", aluout_m, npc_m);
        end
        dstall = 1'b0; dhit = 1'b0; ihit = 1'b0; rdat1_r = 32'd70;
        tick();
        n_cmp++;
        if (aluout_m !== 32'd42) begin
            n_fail++;
            $display("FAIL ihit_hold: got %0d, want 42", aluout_m);
        end
        dstall = 1'b1; nRST = 1'b0;
        #1;
        n_cmp++;
        if (aluout_m !== 32'd0 || npc_m !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_in_stall: got alu=%0d npc=%h, want 0 0", aluout_m, npc_m);
        end
        clear_inputs();
        #2 nRST = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdat1_r = 32'd10 * i; rdat2_r = 32'd3; wreg_r = 5'(i + 1);
            tick();
            n_cmp++;
            if (aluout_m !== 32'd10 * i + 32'd3 || wreg_m !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b%0d: got alu=%0d wreg=%0d, want %0d %0d",
                         i, aluout_m, wreg_m, 10 * i + 3, i + 1);
            end
        end
        clear_inputs();
    endtask

    task automatic test_flush_halt();
        ihit = 1'b1; rdat1_r = 32'd8; rdat2_r = 32'd8; Reg_Wen_r = 1'b1; dren_r = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (Reg_Wen_m !== 1'b0 || dren_m !== 1'b0 || aluout_m !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got wen=%b dren=%b alu=%0d, want 0 0 0", Reg_Wen_m, dren_m, aluout_m);
        end
        flush = 1'b0;
        tick();
        flush = 1'b1; ihit = 1'b0;
        tick();
        n_cmp++;
        if (Reg_Wen_m !== 1'b1 || aluout_m !== 32'd16) begin
            n_fail++;
            $display("FAIL flush_noen_hold: got wen=%b alu=%0d, want 1 16", Reg_Wen_m, aluout_m);
        end
        flush = 1'b0; ihit = 1'b1; halt_r = 1'b1; rdat1_r = 32'd1; rdat2_r = 32'd1;
        tick();
        n_cmp++;
        if (halt_m !== 1'b1 || aluout_m !== 32'd2) begin
            n_fail++;
            $display("FAIL halt_load: got halt=%b alu=%0d, want 1 2", halt_m, aluout_m);
        end
        halt_r = 1'b0; rdat1_r = 32'd50; jrtype_r = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (halt_m !== 1'b1 || aluout_m !== 32'd2) begin
            n_fail++;
            $display("FAIL halt_sticky: got halt=%b alu=%0d, want 1 2", halt_m, aluout_m);
        end
        n_cmp++;
        if (pc_redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_redirect: got %b, want 0", pc_redirect);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (halt_m !== 1'b0 || aluout_m !== 32'd0 || pc_redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reset: got halt=%b alu=%0d redir=%b, want 0 0 1", halt_m, aluout_m, pc_redirect);
        end
        clear_inputs();
        #2 nRST = 1'b1;
        tick();
    endtask

    task automatic test_alu_corners();
        logic [31:0] exp_res [6];
        aluop_t      ops     [6];
        logic [31:0] av      [6];
        logic [31:0] bv      [6];
        logic [31:0] ev      [6];
        ops[0] = ALU_SLT;  av[0] = 32'h8000_0000; bv[0] = 32'd1; ev[0] = 32'd0;   exp_res[0] = 32'd1;
        ops[1] = ALU_SLTU; av[1] = 32'h8000_0000; bv[1] = 32'd1; ev[1] = 32'd0;   exp_res[1] = 32'd0;
        ops[2] = ALU_SUB;  av[2] = 32'd0;         bv[2] = 32'd1; ev[2] = 32'd0;   exp_res[2] = 32'hFFFF_FFFF;
        ops[3] = ALU_SLL;  av[3] = 32'd0;         bv[3] = 32'd1; ev[3] = 32'h7C0; exp_res[3] = 32'h8000_0000;
        ops[4] = ALU_SRL;  av[4] = 32'd0;         bv[4] = 32'h8000_0000; ev[4] = 32'h7C0; exp_res[4] = 32'd1;
        ops[5] = ALU_NOR;  av[5] = 32'h0F0F_0000; bv[5] = 32'h0000_00FF; ev[5] = 32'd0; exp_res[5] = 32'hF0F0_FF00;
        ihit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ALUOP_r = ops[i]; rdat1_r = av[i]; rdat2_r = bv[i]; extOut_r = ev[i];
            tick();
            n_cmp++;
            if (aluout_m !== exp_res[i]) begin
                n_fail++;
                $display("FAIL alu_%s: got %h, want %h", ops[i].name(), aluout_m, exp_res[i]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_inputs();
        nRST = 1'b0;
        test_reset();
        test_forward();
        test_store_imm();
        test_branch();
        test_stall_hold();
        test_back_to_back();
        test_flush_halt();
        test_alu_corners();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
